// File: rtl/rf_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arbiter_if
// Description : Requester-side bundle for the register-file write arbiter.
//               NREQ valid/ready channels, each carrying a destination address
//               and an 8-bit write data word, packed by requester index.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int PW   = 3
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*PW-1:0] req_addr;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;

  // Requesters drive the payload and see the grant.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // The arbiter consumes the payload and returns the one-hot grant.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port among NREQ requesters. One registered write stage drives
//               wr_en/wr_addr/dat_in; busy_vec flags the in-flight destination.
//               Optional r0 protection with a saturating drop counter.
//               Optional macro RF_WR_BYPASS_EN adds two read-port forwarding
//               muxes fed from the write stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
  parameter int PW      = 3,
  parameter int NREQ    = 3,
  parameter int LOCK_R0 = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  rf_wr_arbiter_if.slave            req,
  input  wire logic                 hold,
  output logic                      wr_en,
  output logic [PW-1:0]             wr_addr,
  output logic [7:0]                dat_in,
  output logic [(1<<PW)-1:0]        busy_vec,
  output logic [7:0]                drop_cnt
`ifdef RF_WR_BYPASS_EN
  ,
  input  wire logic [PW-1:0]        rd_addrA,
  input  wire logic [PW-1:0]        rd_addrB,
  input  wire logic [7:0]           rf_datA,
  input  wire logic [7:0]           rf_datB,
  output logic [7:0]                fwd_datA,
  output logic [7:0]                fwd_datB
`endif
);

  localparam int c_NREGS = 1 << PW;
  localparam int c_PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Write stage and arbitration state
  logic              r_stage_valid;
  logic [PW-1:0]     r_wr_addr;
  logic [7:0]        r_dat_in;
  logic [c_PTRW-1:0] r_rr_ptr;
  logic [7:0]        r_drop_cnt;

  // Arbitration results
  logic [NREQ-1:0]   w_grant;
  logic [c_PTRW-1:0] w_gidx;
  logic [c_PTRW-1:0] w_scan;
  logic [c_PTRW-1:0] w_next_ptr;
  logic              w_found;
  logic              w_accept;
  logic              w_drop;
  logic [PW-1:0]     w_sel_addr;
  logic [7:0]        w_sel_data;
  int                w_pos;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_scan  = '0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(r_rr_ptr) + k;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end
      w_scan = c_PTRW'(w_pos);
      if (!w_found && req.req_valid[w_scan]) begin
        w_found         = 1'b1;
        w_gidx          = w_scan;
        w_grant[w_scan] = 1'b1;
      end
    end
  end

  // Payload mux driven only by the granted lane so idle lanes' X never leaks.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req.req_addr[i*PW +: PW];
        w_sel_data = req.req_data[i*8 +: 8];
      end
    end
  end

  assign req.req_ready = hold ? '0 : w_grant;
  assign w_accept      = w_found & ~hold;
  assign w_next_ptr    = (w_gidx == c_PTRW'(NREQ - 1)) ? '0 : (w_gidx + c_PTRW'(1));
  assign w_drop        = (LOCK_R0 != 0) && (w_sel_addr == '0);

  // Write stage, pointer advance and r0 drop counter; hold freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_valid <= 1'b0;
      r_wr_addr     <= '0;
      r_dat_in      <= '0;
      r_rr_ptr      <= '0;
      r_drop_cnt    <= '0;
    end else if (!hold) begin
      if (w_accept) begin
        r_rr_ptr <= w_next_ptr;
        if (w_drop) begin
          r_stage_valid <= 1'b0;
          if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end else begin
          r_stage_valid <= 1'b1;
          r_wr_addr     <= w_sel_addr;
          r_dat_in      <= w_sel_data;
        end
      end else begin
        r_stage_valid <= 1'b0;
      end
    end
  end

  assign wr_en    = r_stage_valid & ~hold;
  assign wr_addr  = r_wr_addr;
  assign dat_in   = r_dat_in;
  assign drop_cnt = r_drop_cnt;

  // One-hot flag of the destination currently parked in the stage.
  always_comb begin
    busy_vec = '0;
    for (int k = 0; k < c_NREGS; k++) begin
      busy_vec[k] = r_stage_valid && (r_wr_addr == PW'(k));
    end
  end

`ifdef RF_WR_BYPASS_EN
  // Forward the in-flight write to a reader of the same register (never r0 when locked).
  always_comb begin
    fwd_datA = rf_datA;
    fwd_datB = rf_datB;
    if (wr_en && (wr_addr == rd_addrA) && !((LOCK_R0 != 0) && (rd_addrA == '0))) begin
      fwd_datA = dat_in;
    end
    if (wr_en && (wr_addr == rd_addrB) && !((LOCK_R0 != 0) && (rd_addrB == '0))) begin
      fwd_datB = dat_in;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wr_arbiter
// Description : Directed self-checking bench for rf_wr_arbiter. Expected
//               writes are queued at grant time and matched when wr_en fires.
//               Exercises RF_WR_BYPASS_EN forwarding when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;
  localparam int PW   = 3;
  localparam int NREQ = 3;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic hold;

  logic            wr_en,    wr_en_nl;
  logic [PW-1:0]   wr_addr,  wr_addr_nl;
  logic [7:0]      dat_in,   dat_in_nl;
  logic [7:0]      busy_vec, busy_vec_nl;
  logic [7:0]      drop_cnt, drop_cnt_nl;

`ifdef RF_WR_BYPASS_EN
  logic [PW-1:0] rd_addrA, rd_addrB;
  logic [7:0]    rf_datA, rf_datB;
  logic [7:0]    fwd_datA, fwd_datB, fwd_datA_nl, fwd_datB_nl;
`endif

  int tests = 0;
  int fails = 0;
  wr_t sb[$];

  rf_wr_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus ();
  rf_wr_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus_nl ();

  rf_wr_arbiter #(.PW(PW), .NREQ(NREQ), .LOCK_R0(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.slave),
    .hold     (hold),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .dat_in   (dat_in),
    .busy_vec (busy_vec),
    .drop_cnt (drop_cnt)
`ifdef RF_WR_BYPASS_EN
    ,
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .rf_datA  (rf_datA),
    .rf_datB  (rf_datB),
    .fwd_datA (fwd_datA),
    .fwd_datB (fwd_datB)
`endif
  );

  rf_wr_arbiter #(.PW(PW), .NREQ(NREQ), .LOCK_R0(0)) dut_nl (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus_nl.slave),
    .hold     (hold),
    .wr_en    (wr_en_nl),
    .wr_addr  (wr_addr_nl),
    .dat_in   (dat_in_nl),
    .busy_vec (busy_vec_nl),
    .drop_cnt (drop_cnt_nl)
`ifdef RF_WR_BYPASS_EN
    ,
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .rf_datA  (rf_datA),
    .rf_datB  (rf_datB),
    .fwd_datA (fwd_datA_nl),
    .fwd_datB (fwd_datB_nl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [PW-1:0] a, input logic [7:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*PW +: PW]  = a;
    bus.req_data[i*8 +: 8]    = d;
  endtask

  task automatic push(input logic [PW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    hold          = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (wr_en !== 1'b0) begin
      if (sb.size() == 0) begin
        check("wr_en_without_pending", 32'(wr_en), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_wr_addr", 32'(wr_addr), 32'(e.addr));
        check("sb_dat_in", 32'(dat_in), 32'(e.data));
        check("sb_busy_vec", 32'(busy_vec), 32'd1 << e.addr);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus_nl.req_valid = '0;
    bus_nl.req_addr  = '0;
    bus_nl.req_data  = '0;
`ifdef RF_WR_BYPASS_EN
    rd_addrA = '0;
    rd_addrB = '0;
    rf_datA  = '0;
    rf_datB  = '0;
`endif
    cyc();
    cyc();
    rst_n = 1'b1;
    settle();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_dat_in", 32'(dat_in), 32'd0);
    check("rst_busy_vec", 32'(busy_vec), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);

    // Single write: requester 1 -> r5 = 0xA3
    set_req(1, 1'b1, 3'd5, 8'hA3);
    settle();
    check("single_ready", 32'(bus.req_ready), 32'b010);
    push(3'd5, 8'hA3);
    cyc();
    set_req(1, 1'b0, 3'd0, 8'h00);
    settle();
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd5);
    check("single_dat_in", 32'(dat_in), 32'hA3);
    check("single_busy", 32'(busy_vec), 32'h20);

    // All three requesters valid for six cycles: 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        set_req(r, 1'b1, PW'(r + 1), {4'(i), 4'(r)});
      end
      settle();
      check("rr_ready", 32'(bus.req_ready), 32'd1 << (i % 3));
      push(PW'((i % 3) + 1), {4'(i), 4'(i % 3)});
      cyc();
    end
    bus.req_valid = '0;
    settle();
    check("rr_last_wr_en", 32'(wr_en), 32'd1);

    // Accept to r4 then hold three cycles; a later requester waits behind hold
    do_reset();
    set_req(0, 1'b1, 3'd4, 8'h44);
    settle();
    check("hold_accept_ready", 32'(bus.req_ready), 32'b001);
    push(3'd4, 8'h44);
    cyc();
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(2, 1'b1, 3'd3, 8'h33);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_wr_en", 32'(wr_en), 32'd0);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_busy", 32'(busy_vec), 32'h10);
      check("hold_wr_addr", 32'(wr_addr), 32'd4);
      cyc();
    end
    hold = 1'b0;
    settle();
    check("release_wr_en", 32'(wr_en), 32'd1);
    check("release_ready", 32'(bus.req_ready), 32'b100);
    push(3'd3, 8'h33);
    cyc();
    set_req(2, 1'b0, 3'd0, 8'h00);
    settle();
    check("release_next_addr", 32'(wr_addr), 32'd3);

    // r0 writes: discarded and counted when locked, written when not
    do_reset();
    set_req(0, 1'b1, 3'd0, 8'hEE);
    bus_nl.req_valid[0]  = 1'b1;
    bus_nl.req_addr[2:0] = 3'd0;
    bus_nl.req_data[7:0] = 8'h77;
    settle();
    check("r0_ready", 32'(bus.req_ready), 32'b001);
    cyc();
    bus_nl.req_valid[0] = 1'b0;
    settle();
    check("r0_lock_wr_en", 32'(wr_en), 32'd0);
    check("r0_lock_busy", 32'(busy_vec), 32'd0);
    check("r0_nolock_wr_en", 32'(wr_en_nl), 32'd1);
    check("r0_nolock_wr_addr", 32'(wr_addr_nl), 32'd0);
    check("r0_nolock_dat_in", 32'(dat_in_nl), 32'h77);
    check("r0_nolock_busy", 32'(busy_vec_nl), 32'h01);
    check("r0_nolock_drop", 32'(drop_cnt_nl), 32'd0);
    repeat (99) cyc();
    settle();
    check("r0_drop_100", 32'(drop_cnt), 32'd100);
    repeat (200) cyc();
    settle();
    check("r0_drop_sat", 32'(drop_cnt), 32'd255);
    check("r0_sat_wr_en", 32'(wr_en), 32'd0);

    // Reset while an accepted write is still parked in the stage
    do_reset();
    set_req(1, 1'b1, 3'd6, 8'h66);
    settle();
    check("rstacc_ready", 32'(bus.req_ready), 32'b010);
    cyc();
    bus.req_valid = '0;
    hold  = 1'b1;
    rst_n = 1'b0;
    settle();
    check("rstacc_busy_pending", 32'(busy_vec), 32'h40);
    cyc();
    hold  = 1'b0;
    rst_n = 1'b1;
    settle();
    check("rstacc_wr_en", 32'(wr_en), 32'd0);
    check("rstacc_wr_addr", 32'(wr_addr), 32'd0);
    check("rstacc_dat_in", 32'(dat_in), 32'd0);
    check("rstacc_busy", 32'(busy_vec), 32'd0);
    check("rstacc_drop", 32'(drop_cnt), 32'd0);
    for (int r = 0; r < NREQ; r++) begin
      set_req(r, 1'b1, PW'(r + 1), 8'hB0 + 8'(r));
    end
    settle();
    check("rstacc_ptr_zero", 32'(bus.req_ready), 32'b001);
    push(3'd1, 8'hB0);
    cyc();
    bus.req_valid = '0;
    cyc();

`ifdef RF_WR_BYPASS_EN
    // Forwarding from the write stage
    do_reset();
    set_req(0, 1'b1, 3'd2, 8'h5C);
    push(3'd2, 8'h5C);
    cyc();
    set_req(0, 1'b0, 3'd0, 8'h00);
    rd_addrA = 3'd2;
    rf_datA  = 8'h11;
    rd_addrB = 3'd3;
    rf_datB  = 8'h22;
    hold     = 1'b1;
    settle();
    check("fwd_hold_A", 32'(fwd_datA), 32'h11);
    cyc();
    hold = 1'b0;
    settle();
    check("fwd_A", 32'(fwd_datA), 32'h5C);
    check("fwd_B_nomatch", 32'(fwd_datB), 32'h22);
    cyc();
`endif

    cyc();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
